// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the seven-segment scan mux
//
// Purpose: scan FSM state type, the all-segments-off code and the
//          hex-to-segment table ({g,f,e,d,c,b,a}, active-low).
// Ports:   none (package).
package seg_pkg;

  typedef enum logic {SHOW, BLANK} scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index = nibble value; 0 bit = segment lit.
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_mux_if.sv
// rtl/seg_scan_mux_if.sv - user-logic update bus for the seven-segment scan mux
//
// Purpose: groups the value/enable/load inputs and the pending flag.
// Signals: digits_in [4*NUM_DIGITS] hex nibbles, digit 0 = [3:0]
//          digit_en  [NUM_DIGITS]   per-digit anode enable (live)
//          load                     1-cycle capture strobe
//          pending                  capture waiting for the next frame boundary
// Modports: master = user logic, slave = scan mux.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic                    pending;

  modport master (output digits_in, output digit_en, output load, input pending);
  modport slave  (input digits_in, input digit_en, input load, output pending);
endinterface

// File: rtl/seg_hex_decoder.sv
// rtl/seg_hex_decoder.sv - combinational nibble to seven-segment decoder
//
// Purpose: table lookup of one hex nibble into active-low segments.
// Ports:   i_nibble [4] value to show
//          o_seg    [7] {g,f,e,d,c,b,a}, active-low
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - N-digit common-anode seven-segment scan multiplexer
//
// Purpose: scans one digit at a time with an all-off gap between digits;
//          user updates are captured into a pending register and committed
//          to the displayed value only at the frame boundary (wrap to digit 0).
// Ports:   clk        system clock
//          reset      asynchronous active-low reset
//          upd        seg_scan_mux_if.slave (digits_in, digit_en, load, pending)
//          seg        [7] {g,f,e,d,c,b,a}, active-low, registered
//          anodes     [NUM_DIGITS] one-hot active-low anode select, registered
//          frame_tick 1-cycle pulse when the scan wraps to digit 0
// Config:  LEADING_ZERO_BLANK_EN - blank leading zero digits (digit 0 always shown).
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 24000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  seg_scan_mux_if.slave         upd,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic                  frame_tick
);

  localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic                    w_boundary;

  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_pend_data;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic                    r_frame_tick;

  logic [3:0]              w_nibble;
  logic [6:0]              w_dec_seg;
  logic                    w_lz_blank;
  logic [6:0]              w_seg_nxt;
  logic [NUM_DIGITS-1:0]   w_anodes_nxt;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_anodes;

  // Reset lands in BLANK on the last digit so the first wrap (and commit)
  // happens after one blanking gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= BLANK;
      r_cnt   <= '0;
      r_idx   <= IDX_LAST;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_boundary  = 1'b0;
    case (r_state)
      SHOW: begin
        if (r_cnt == DIGIT_LAST) begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
        end
      end
      BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = SHOW;
          w_cnt_nxt   = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt  = '0;
            w_boundary = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = BLANK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A load on the boundary cycle commits the older pending data (NBA reads
  // the old r_pend_data) while capturing the new one, so pending stays set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending    <= 1'b0;
      r_pend_data  <= '0;
      r_active     <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_boundary;
      if (w_boundary && r_pending) begin
        r_active <= r_pend_data;
      end
      if (upd.load) begin
        r_pend_data <= upd.digits_in;
        r_pending   <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    w_nibble = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nibble = r_active[4*k +: 4];
      end
    end
  end

  seg_hex_decoder u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k>0 is a leading zero when it and every higher nibble are zero.
  always_comb begin
    w_lz_blank = 1'b0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_lz_blank = ((r_active >> (4*k)) == '0);
      end
    end
  end
`else
  assign w_lz_blank = 1'b0;
`endif

  // digit_en is read live so an enable change takes effect in the current slot.
  always_comb begin
    w_anodes_nxt = '1;
    w_seg_nxt    = SEG_OFF;
    if (r_state == SHOW) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (r_idx == IDX_W'(k)) begin
          w_anodes_nxt[k] = ~upd.digit_en[k];
        end
      end
      w_seg_nxt = w_lz_blank ? SEG_OFF : w_dec_seg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg    <= SEG_OFF;
      r_anodes <= '1;
    end else begin
      r_seg    <= w_seg_nxt;
      r_anodes <= w_anodes_nxt;
    end
  end

  assign seg         = r_seg;
  assign anodes      = r_anodes;
  assign frame_tick  = r_frame_tick;
  assign upd.pending = r_pending;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - self-checking bench for seg_scan_mux
module tb_seg_scan_mux;

  localparam int N = 4;
  localparam int D = 4;
  localparam int B = 2;
  localparam int P = D + B;
  localparam int F = N * P;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [6:0]   seg;
  logic [N-1:0] anodes;
  logic         frame_tick;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg_scan_mux_if #(.NUM_DIGITS(N)) upd();

  seg_scan_mux #(
    .NUM_DIGITS   (N),
    .DIGIT_CYCLES (D),
    .BLANK_CYCLES (B)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .upd        (upd),
    .seg        (seg),
    .anodes     (anodes),
    .frame_tick (frame_tick)
  );

  // Standard hex glyphs, {g,f,e,d,c,b,a}, 0 = lit.
  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline after reset release: n edges elapsed. First B edges are blank,
  // then each frame of F edges is N slots of D lit + B blank.
  function automatic void slot_of(input int n, output bit show, output int dig);
    int v;
    if (n < B) begin
      show = 1'b0;
      dig  = N - 1;
    end else begin
      v    = (n - B) % F;
      dig  = v / P;
      show = (v % P) < D;
    end
  endfunction

  int           m_n;
  bit           m_pend;
  logic [15:0]  m_pdata;
  logic [15:0]  m_active;
  logic [6:0]   e_seg;
  logic [N-1:0] e_an;
  bit           e_tick;

  always @(posedge clk or negedge rst_n) begin
    bit          sh;
    int          dg;
    int          n;
    bit          bnd;
    logic [6:0]  s;
    logic [N-1:0] a;
    if (!rst_n) begin
      m_n      <= 0;
      m_pend   <= 1'b0;
      m_pdata  <= '0;
      m_active <= '0;
      e_seg    <= 7'h7F;
      e_an     <= '1;
      e_tick   <= 1'b0;
    end else begin
      slot_of(m_n, sh, dg);
      s = 7'h7F;
      a = '1;
      if (sh) begin
        a[dg] = ~upd.digit_en[dg];
        s     = glyph[m_active[4*dg +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
        if (dg > 0 && (m_active >> (4*dg)) == 16'h0) s = 7'h7F;
`endif
      end
      n   = m_n + 1;
      bnd = (n >= B) && (((n - B) % F) == 0);
      e_seg  <= s;
      e_an   <= a;
      e_tick <= bnd;
      if (bnd && m_pend) m_active <= m_pdata;
      if (upd.load) begin
        m_pdata <= upd.digits_in;
        m_pend  <= 1'b1;
      end else if (bnd) begin
        m_pend <= 1'b0;
      end
      m_n <= n;
    end
  end

  always @(negedge clk) begin
    check("seg", 32'(seg), 32'(e_seg));
    check("anodes", 32'(anodes), 32'(e_an));
    check("frame_tick", 32'(frame_tick), 32'(e_tick));
    check("pending", 32'(upd.pending), 32'(m_pend));
    check("one_anode", 32'($countones(~anodes) <= 1), 32'd1);
  end

  task automatic wait_tick();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (frame_tick) break;
    end
    tests++;
    if (k == 40) begin
      fails++;
      $display("FAIL wait_tick: got no frame_tick, expected one within 40 cycles");
    end
  endtask

  task automatic pulse_load(input logic [15:0] data);
    upd.digits_in = data;
    upd.load      = 1'b1;
    @(posedge clk);
    #1 upd.load = 1'b0;
  endtask

  initial begin
    int c79, c12, c_on, c_off02;
    upd.load      = 1'b0;
    upd.digits_in = '0;
    upd.digit_en  = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_anodes", 32'(anodes), 32'hF);
    check("rst_pending", 32'(upd.pending), 32'h0);
    check("rst_tick", 32'(frame_tick), 32'h0);

    // 1: first frame after reset
    rst_n = 1'b1;
    pulse_load(16'h8510);
    @(posedge clk); @(negedge clk);
    check("t1_tick_at_2", 32'(frame_tick), 32'h1);
    check("t1_pend_clear", 32'(upd.pending), 32'h0);
    @(negedge clk);
    check("t1_d0_an", 32'(anodes), 32'hE);
    check("t1_d0_seg", 32'(seg), 32'h40);
    repeat (4) @(negedge clk);
    check("t1_gap_an", 32'(anodes), 32'hF);
    repeat (2) @(negedge clk);
    check("t1_d1_an", 32'(anodes), 32'hD);
    check("t1_d1_seg", 32'(seg), 32'h79);
    repeat (6) @(negedge clk);
    check("t1_d2_an", 32'(anodes), 32'hB);
    check("t1_d2_seg", 32'(seg), 32'h12);
    repeat (6) @(negedge clk);
    check("t1_d3_an", 32'(anodes), 32'h7);
    check("t1_d3_seg", 32'(seg), 32'h00);

    // 2: mid-frame load waits for the boundary
    pulse_load(16'hFFFF);
    @(negedge clk);
    check("t2_pending", 32'(upd.pending), 32'h1);
    check("t2_old_seg", 32'(seg), 32'h00);
    wait_tick();
    check("t2_pend_clear", 32'(upd.pending), 32'h0);
    @(negedge clk);
    check("t2_new_seg", 32'(seg), 32'h0E);

    // 3: second load replaces the first; load on the boundary cycle
    pulse_load(16'h1111);
    repeat (3) @(negedge clk);
    pulse_load(16'h5555);
    wait_tick();
    c79 = 0;
    c12 = 0;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      if (seg == 7'h79) c79++;
      if (seg == 7'h12) c12++;
    end
    check("t3_no_ones", 32'(c79), 32'd0);
    check("t3_fives", 32'(c12), 32'd16);
    upd.digits_in = 16'hA5C3;
    upd.load      = 1'b1;
    @(posedge clk);
    #1 upd.load = 1'b0;
    @(negedge clk);
    check("t3_bnd_tick", 32'(frame_tick), 32'h1);
    check("t3_bnd_pend", 32'(upd.pending), 32'h1);

    // 4: digit enables
    upd.digit_en = 4'b1010;
    wait_tick();
    c_on    = 0;
    c_off02 = 0;
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      if (anodes != 4'hF) c_on++;
      if (!anodes[0] || !anodes[2]) c_off02++;
    end
    check("t4_lit_cycles", 32'(c_on), 32'd8);
    check("t4_d0_d2_dark", 32'(c_off02), 32'd0);

    // 5: asynchronous reset in the digit-2 slot
    upd.digit_en = 4'hF;
    wait_tick();
    repeat (12) @(posedge clk);
    #1;
    upd.digits_in = 16'h1234;
    upd.load      = 1'b1;
    @(posedge clk);
    #1 upd.load = 1'b0;
    #1 check("t5_pend_set", 32'(upd.pending), 32'h1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_seg", 32'(seg), 32'h7F);
    check("t5_rst_an", 32'(anodes), 32'hF);
    check("t5_rst_pend", 32'(upd.pending), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_tick_at_2", 32'(frame_tick), 32'h1);
    check("t5_pend_dropped", 32'(upd.pending), 32'h0);
    @(negedge clk);
    check("t5_d0_seg", 32'(seg), 32'h40);
    check("t5_d0_an", 32'(anodes), 32'hE);

`ifdef LEADING_ZERO_BLANK_EN
    // 6: leading zero blanking
    pulse_load(16'h0050);
    wait_tick();
    @(negedge clk);
    check("t6_d0", 32'(seg), 32'h40);
    repeat (6) @(negedge clk);
    check("t6_d1", 32'(seg), 32'h12);
    repeat (6) @(negedge clk);
    check("t6_d2", 32'(seg), 32'h7F);
    check("t6_d2_an", 32'(anodes), 32'hB);
    repeat (6) @(negedge clk);
    check("t6_d3", 32'(seg), 32'h7F);
    pulse_load(16'h0000);
    wait_tick();
    @(negedge clk);
    check("t6z_d0", 32'(seg), 32'h40);
    repeat (6) @(negedge clk);
    check("t6z_d1", 32'(seg), 32'h7F);
`endif

    // Randomized traffic checked by the model every cycle
    repeat (1500) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 15) == 0) upd.digit_en = 4'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        upd.digits_in = 16'($urandom);
        upd.load      = 1'b1;
      end else begin
        upd.load = 1'b0;
      end
    end
    upd.load = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
